// File: rtl/count_sequencer.sv
// Sequencer for the lab counter: clears it, then drives programmed-step sweeps from 0 up to
// a limit, landing exactly on the limit, in one-shot or repeat mode with a start/busy/done handshake.
module count_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic             cfg_repeat,
  input  logic [WIDTH-1:0] cnt_dout,
  output logic             cnt_rst,
  output logic             cnt_en,
  output logic [WIDTH-1:0] cnt_incr,
  output logic             busy,
  output logic             done,
  output logic [7:0]       pass_cnt
);

  // state | meaning
  // IDLE  | waiting for start; cfg_* sampled on start
  // CLEAR | one cycle of counter clear
  // RUN   | advancing the counter towards limit_q
  // DONE  | one-cycle done pulse after a one-shot sweep
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] limit_q, step_q;
  logic             repeat_q;
  logic             latch_cfg, pass_inc;
  logic [WIDTH:0]   remain;

  // Only consumed while cnt_dout < limit_q, so the difference is always positive.
  assign remain = {1'b0, limit_q} - {1'b0, cnt_dout};
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_rst   = 1'b0;
    cnt_en    = 1'b0;
    cnt_incr  = '0;
    done      = 1'b0;
    latch_cfg = 1'b0;
    pass_inc  = 1'b0;
    if (rst) begin
      cnt_rst   = 1'b1;
      state_nxt = IDLE;
    end else if (state != IDLE && abort) begin
      // Counter is left untouched so its value can be inspected after an abort.
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            latch_cfg = 1'b1;
            state_nxt = CLEAR;
          end
        end
        CLEAR: begin
          cnt_rst   = 1'b1;
          state_nxt = RUN;
        end
        RUN: begin
          if (cnt_dout < limit_q) begin
            cnt_en   = 1'b1;
            cnt_incr = ({1'b0, step_q} < remain) ? step_q : remain[WIDTH-1:0];
          end else begin
            pass_inc  = 1'b1;
            state_nxt = repeat_q ? CLEAR : DONE;
          end
        end
        DONE: begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      limit_q  <= '0;
      step_q   <= '0;
      repeat_q <= 1'b0;
      pass_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (latch_cfg) begin
        limit_q  <= cfg_limit;
        step_q   <= (cfg_step == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : cfg_step;
        repeat_q <= cfg_repeat;
        pass_cnt <= '0;
      end else if (pass_inc && pass_cnt != 8'hFF) begin
        pass_cnt <= pass_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer with a behavioural counter; directed and random sweeps are
// scoreboarded against expected counter values, increments and done timing.
module tb_count_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, abort, cfg_repeat;
  logic [7:0] cfg_limit, cfg_step, cnt_dout, cnt_incr, pass_cnt;
  logic       cnt_rst, cnt_en, busy, done;
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;

  typedef struct {int d; int inc;} en_t;
  typedef struct {int cyc; int lim;} done_t;
  en_t   eq[$];
  done_t dq[$];

  count_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_limit(cfg_limit), .cfg_step(cfg_step), .cfg_repeat(cfg_repeat),
    .cnt_dout(cnt_dout), .cnt_rst(cnt_rst), .cnt_en(cnt_en), .cnt_incr(cnt_incr),
    .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Lab counter: synchronous clear, advance by incr when enabled.
  always @(posedge clk) begin
    if (cnt_rst) cnt_dout <= 8'd0;
    else if (cnt_en) cnt_dout <= cnt_dout + cnt_incr;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sweep's worth of expected enabled cycles: dout climbs by min(step, remaining).
  task automatic push_sweep(input int lim, input int stp);
    int s, v, inc;
    s = (stp == 0) ? 1 : stp;
    v = 0;
    while (v < lim) begin
      inc = (s < lim - v) ? s : lim - v;
      eq.push_back('{v, inc});
      v += inc;
    end
  endtask

  // Monitor: checks every enabled cycle and every done pulse against the queues.
  initial begin
    en_t   e;
    done_t d;
    forever begin
      @(negedge clk);
      if (cnt_en === 1'b1) begin
        if (eq.size() == 0) chk("unexpected_en", 1, 0);
        else begin
          e = eq.pop_front();
          chk("run_dout", int'(cnt_dout), e.d);
          chk("run_incr", int'(cnt_incr), e.inc);
        end
      end else if (cnt_en === 1'b0) begin
        chk("incr_idle_zero", int'(cnt_incr), 0);
      end
      if (done === 1'b1) begin
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          d = dq.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_dout", int'(cnt_dout), d.lim);
          chk("done_pass", int'(pass_cnt), 1);
        end
      end
    end
  end

  task automatic run_oneshot(input int lim, input int stp);
    int c, s, n, e;
    c = cyc;
    s = (stp == 0) ? 1 : stp;
    n = (lim + s - 1) / s;
    push_sweep(lim, stp);
    dq.push_back('{c + 3 + n, lim});
    cfg_limit = 8'(lim); cfg_step = 8'(stp); cfg_repeat = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    cfg_limit = 8'($urandom); cfg_step = 8'($urandom); cfg_repeat = 1'($urandom);
    step();
    start = 1'b1;  // ignored while busy
    step();
    start = 1'b0;
    e = 0;
    while (busy && e < 400) begin
      step();
      e++;
    end
    chk("sweep_timeout", e < 400 ? 1 : 0, 1);
    chk("idle_after_done", int'(busy), 0);
    chk("done_consumed", dq.size(), 0);
    chk("final_pass", int'(pass_cnt), 1);
    chk("final_dout", int'(cnt_dout), lim);
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_limit = 8'd0; cfg_step = 8'd0; cfg_repeat = 1'b0;
    step();
    step();
    chk("rst_cnt_rst", int'(cnt_rst), 1);
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass_cnt), 0);
    chk("rst_en", int'(cnt_en), 0);
    chk("rst_dout", int'(cnt_dout), 0);
    step();

    run_oneshot(10, 3);
    run_oneshot(3, 0);
    run_oneshot(0, 5);
    run_oneshot(255, 200);
    for (int i = 0; i < 20; i++) begin
      run_oneshot($urandom_range(0, 255),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 8));
      step();
    end

    // Repeat mode: four-cycle passes, pass_cnt = number of completed passes.
    c = cyc;
    for (int p = 0; p < 3; p++) push_sweep(4, 2);
    cfg_limit = 8'd4; cfg_step = 8'd2; cfg_repeat = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      chk("rep_pass", int'(pass_cnt), (k - 1) / 4);
      chk("rep_busy", int'(busy), 1);
      if (k < 13) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("rep_abort_busy", int'(busy), 0);
    chk("rep_abort_dout", int'(cnt_dout), 4);
    chk("rep_abort_pass", int'(pass_cnt), 3);
    chk("rep_start_cycle", c, cyc - 14);
    step();

    // Abort on cycle 4 of a sweep: counter holds its value.
    push_sweep(4, 2);
    cfg_limit = 8'd10; cfg_step = 8'd2; cfg_repeat = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("abort_pre_dout", int'(cnt_dout), 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_dout", int'(cnt_dout), 4);
    chk("abort_pass", int'(pass_cnt), 0);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", int'(busy), 0);
    step();
    chk("start_abort_busy2", int'(busy), 0);
    chk("start_abort_dout", int'(cnt_dout), 4);

    // Reset mid-RUN at dout = 6 during the second repeat pass.
    push_sweep(6, 3);
    push_sweep(6, 3);
    cfg_limit = 8'd6; cfg_step = 8'd3; cfg_repeat = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("mid_dout", int'(cnt_dout), 6);
    chk("mid_pass", int'(pass_cnt), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_pass", int'(pass_cnt), 0);
    chk("mid_rst_dout", int'(cnt_dout), 0);
    step(); step();

    chk("en_queue_empty", eq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
